// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed scan of a common-anode 7-segment display with optional blanking gap.
// Define SEG_LZB_EN to enable leading-zero blanking of the upper digits.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_en,
  input  logic                          load_en,
  input  logic [4*NUM_DIGITS-1:0]       data_in,
  output logic [3:0]                    digit_val,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic                          frame_tick
);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int MX = SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC;
  localparam int CW = $clog2(MX + 1);
  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;
  localparam logic [SW-1:0] LAST = SW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SHOW_END  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC == 0 ? 0 : BLANK_CYC - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [0:0]              state;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [SW-1:0]           nxt, ent_sel;
  logic                    show_end, blank_end, enter, lit;
  logic [3:0]              nibble;

  // ent_sel is the digit about to be lit: the held one after a gap, the next one when gapless
  always_comb begin
    nxt       = digit_sel == LAST ? '0 : digit_sel + 1'b1;
    show_end  = state == SHOW && cnt == SHOW_END;
    blank_end = state == BLANK && (BLANK_CYC == 0 || cnt == BLANK_END);
    enter     = blank_end || (show_end && BLANK_CYC == 0);
    ent_sel   = state == SHOW ? nxt : digit_sel;
    nibble    = 4'(shadow >> (4 * ent_sel));
`ifdef SEG_LZB_EN
    lit       = ent_sel == '0 || (shadow >> (4 * ent_sel)) != '0;
`else
    lit       = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      shadow     <= '0;
      digit_sel  <= '0;
      digit_val  <= '0;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (load_en) shadow <= data_in;
      frame_tick <= 1'b0;
      if (!disp_en) begin
        state  <= BLANK;
        cnt    <= '0;
        an_out <= '1;
      end else begin
        cnt <= (blank_end || show_end) ? '0 : cnt + 1'b1;
        if (show_end) begin
          digit_sel  <= nxt;
          frame_tick <= digit_sel == LAST;
        end
        if (enter) begin
          state     <= SHOW;
          digit_val <= nibble;
          an_out    <= lit ? ~(ONE << ent_sel) : '1;
        end else if (show_end) begin
          state  <= BLANK;
          an_out <= '1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed checks of scan order, load timing, disable, async reset and gapless scan.
module tb_seven_seg_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, disp_en = 1'b0, load_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] digit_val, an_out, dv0, an0;
  logic [1:0] digit_sel, sel0;
  logic frame_tick, ft0;
  int checks = 0, failures = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .load_en(load_en), .data_in(data_in),
    .digit_val(digit_val), .digit_sel(digit_sel), .an_out(an_out), .frame_tick(frame_tick));

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .load_en(load_en), .data_in(data_in),
    .digit_val(dv0), .digit_sel(sel0), .an_out(an0), .frame_tick(ft0));

  always #5 clk = ~clk;

  task automatic cyc;
    @(negedge clk);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    logic [15:0] t;
    t = v >> (4 * d);
    return t[3:0];
  endfunction

  function automatic logic [3:0] anode(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic wait_an(input logic [3:0] e, input string nm);
    int n;
    n = 0;
    while (an_out !== e && n < 100) begin cyc(); n++; end
    checks++;
    if (an_out !== e) begin
      failures++;
      $display("FAIL %s: timeout, an_out=%b required %b", nm, an_out, e);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; disp_en = 1'b1; load_en = 1'b1; data_in = 16'h1234;
    cyc(); cyc();
    checks += 4;
    if (an_out !== 4'hF) begin failures++; $display("FAIL reset_an: got %b want 1111", an_out); end
    if (digit_sel !== 2'd0) begin failures++; $display("FAIL reset_sel: got %0d want 0", digit_sel); end
    if (digit_val !== 4'h0) begin failures++; $display("FAIL reset_val: got %h want 0", digit_val); end
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
  endtask

  task automatic test_scan;
    logic [3:0] ea;
    int d, q, ticks;
    ticks = 0;
    rst_n = 1'b1;
    checks++;
    if (an_out !== 4'hF) begin failures++; $display("FAIL scan_pre: got %b want 1111", an_out); end
    for (int k = 1; k <= 48; k++) begin
      cyc();
      if (k == 1) load_en = 1'b0;
      d = k < 2 ? 0 : ((k - 2) / 6) % 4;
      q = k < 2 ? 5 : (k - 2) % 6;
      ea = q < 4 ? anode(d) : 4'hF;
      checks += 2;
      if (an_out !== ea) begin failures++; $display("FAIL scan_an k=%0d: got %b want %b", k, an_out, ea); end
      if (frame_tick !== (k % 24 == 0)) begin failures++; $display("FAIL scan_tick k=%0d: got %b", k, frame_tick); end
      if (frame_tick === 1'b1) ticks++;
      if (q < 4) begin
        checks += 2;
        if (digit_val !== nib(16'h1234, d)) begin failures++; $display("FAIL scan_val k=%0d: got %h want %h", k, digit_val, nib(16'h1234, d)); end
        if (digit_sel !== 2'(d)) begin failures++; $display("FAIL scan_sel k=%0d: got %0d want %0d", k, digit_sel, d); end
      end
    end
    checks++;
    if (ticks != 2) begin failures++; $display("FAIL scan_tick_count: got %0d want 2", ticks); end
  endtask

  task automatic test_load_mid;
    wait_an(4'b1101, "load_d1");
    load_en = 1'b1; data_in = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) load_en = 1'b0;
      checks += 2;
      if (digit_val !== 4'h3) begin failures++; $display("FAIL load_hold i=%0d: got %h want 3", i, digit_val); end
      if (an_out !== 4'b1101) begin failures++; $display("FAIL load_an i=%0d: got %b want 1101", i, an_out); end
    end
    wait_an(4'b1011, "load_d2");
    checks++;
    if (digit_val !== 4'hB) begin failures++; $display("FAIL load_d2_val: got %h want b", digit_val); end
    wait_an(4'b1110, "load_d0");
    checks++;
    if (digit_val !== 4'hD) begin failures++; $display("FAIL load_d0_val: got %h want d", digit_val); end
    wait_an(4'b1101, "load_d1b");
    checks++;
    if (digit_val !== 4'hC) begin failures++; $display("FAIL load_d1_val: got %h want c", digit_val); end
  endtask

  task automatic test_disable;
    wait_an(4'b1011, "dis_d2");
    disp_en = 1'b0;
    cyc();
    load_en = 1'b1; data_in = 16'h1234;
    checks += 2;
    if (an_out !== 4'hF) begin failures++; $display("FAIL dis_an: got %b want 1111", an_out); end
    if (digit_sel !== 2'd2) begin failures++; $display("FAIL dis_sel: got %0d want 2", digit_sel); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      load_en = 1'b0;
      checks += 2;
      if (an_out !== 4'hF) begin failures++; $display("FAIL dis_hold_an i=%0d: got %b want 1111", i, an_out); end
      if (digit_sel !== 2'd2) begin failures++; $display("FAIL dis_hold_sel i=%0d: got %0d want 2", i, digit_sel); end
    end
    disp_en = 1'b1;
    cyc();
    checks++;
    if (an_out !== 4'hF) begin failures++; $display("FAIL reen_blank: got %b want 1111", an_out); end
    cyc();
    checks += 3;
    if (an_out !== 4'b1011) begin failures++; $display("FAIL reen_an: got %b want 1011", an_out); end
    if (digit_val !== 4'h2) begin failures++; $display("FAIL reen_val: got %h want 2", digit_val); end
    if (digit_sel !== 2'd2) begin failures++; $display("FAIL reen_sel: got %0d want 2", digit_sel); end
  endtask

  task automatic test_async_reset;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (an_out !== 4'hF) begin failures++; $display("FAIL areset_an: got %b want 1111", an_out); end
    if (digit_sel !== 2'd0) begin failures++; $display("FAIL areset_sel: got %0d want 0", digit_sel); end
    if (digit_val !== 4'h0) begin failures++; $display("FAIL areset_val: got %h want 0", digit_val); end
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL areset_tick: got %b want 0", frame_tick); end
    load_en = 1'b1; data_in = 16'hFFFF;
    cyc(); cyc();
    load_en = 1'b0; rst_n = 1'b1;
    cyc();
    checks++;
    if (an_out !== 4'hF) begin failures++; $display("FAIL restart_blank: got %b want 1111", an_out); end
    cyc();
    checks += 2;
    if (an_out !== 4'b1110) begin failures++; $display("FAIL restart_an: got %b want 1110", an_out); end
    if (digit_val !== 4'h0) begin failures++; $display("FAIL restart_val: got %h want 0", digit_val); end
`ifndef SEG_LZB_EN
    wait_an(4'b1101, "restart_zero_d1");
    checks++;
    if (digit_val !== 4'h0) begin failures++; $display("FAIL restart_d1_val: got %h want 0", digit_val); end
`endif
  endtask

  task automatic test_no_blank;
    rst_n = 1'b0; disp_en = 1'b0;
    cyc();
    rst_n = 1'b1; load_en = 1'b1; data_in = 16'h1234;
    cyc();
    load_en = 1'b0; disp_en = 1'b1;
    checks++;
    if (an0 !== 4'hF) begin failures++; $display("FAIL nb_pre: got %b want 1111", an0); end
    for (int j = 0; j < 16; j++) begin
      cyc();
      checks += 4;
      if (an0 !== anode(j / 4)) begin failures++; $display("FAIL nb_an j=%0d: got %b want %b", j, an0, anode(j / 4)); end
      if (dv0 !== nib(16'h1234, j / 4)) begin failures++; $display("FAIL nb_val j=%0d: got %h want %h", j, dv0, nib(16'h1234, j / 4)); end
      if (sel0 !== 2'(j / 4)) begin failures++; $display("FAIL nb_sel j=%0d: got %0d want %0d", j, sel0, j / 4); end
      if (ft0 !== 1'b0) begin failures++; $display("FAIL nb_tick j=%0d: got %b want 0", j, ft0); end
    end
    cyc();
    checks += 3;
    if (ft0 !== 1'b1) begin failures++; $display("FAIL nb_wrap_tick: got %b want 1", ft0); end
    if (an0 !== 4'b1110) begin failures++; $display("FAIL nb_wrap_an: got %b want 1110", an0); end
    if (dv0 !== 4'h4) begin failures++; $display("FAIL nb_wrap_val: got %h want 4", dv0); end
  endtask

`ifdef SEG_LZB_EN
  task automatic test_lzb;
    logic [15:0] vals [2];
    logic [3:0] ea;
    int d, q;
    vals[0] = 16'h0050; vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      rst_n = 1'b0; disp_en = 1'b0;
      cyc();
      rst_n = 1'b1; load_en = 1'b1; data_in = vals[v];
      cyc();
      load_en = 1'b0; disp_en = 1'b1;
      for (int k = 1; k <= 24; k++) begin
        cyc();
        d = k < 2 ? 0 : ((k - 2) / 6) % 4;
        q = k < 2 ? 5 : (k - 2) % 6;
        ea = (q < 4 && (d == 0 || (v == 0 && d == 1))) ? anode(d) : 4'hF;
        checks++;
        if (an_out !== ea) begin failures++; $display("FAIL lzb_an v=%0d k=%0d: got %b want %b", v, k, an_out, ea); end
        if (q < 4 && ea != 4'hF) begin
          checks++;
          if (digit_val !== nib(vals[v], d)) begin failures++; $display("FAIL lzb_val v=%0d k=%0d: got %h want %h", v, k, digit_val, nib(vals[v], d)); end
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_load_mid();
    test_disable();
    test_async_reset();
    test_no_blank();
`ifdef SEG_LZB_EN
    test_lzb();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
